// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: operation codes, alu_op classes,
// funct7 patterns and the iterative-unit FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // funct3 map shared by R-type (funct7=0) and I-type
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU-control decode: alu_op/funct3/funct7 -> op code, illegal, multi-cycle flag.
// Zero latency, no handshake of its own.
module alu_decode
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] op_o,
    output logic       illegal_o,
    output logic       multi_o
);

    always_comb begin
        op_o      = OP_ADD;
        illegal_o = 1'b0;
        multi_o   = 1'b0;
        case (alu_op_i)
            ALUOP_MEM: op_o = OP_ADD;
            ALUOP_BR:  op_o = OP_SUB;
            ALUOP_R: begin
                if (funct7_i == F7_BASE) begin
                    op_o = base_op(funct3_i);
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    op_o = OP_SUB;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b101) begin
                    op_o = OP_SRA;
                end else if (ENABLE_M && funct7_i == F7_MULDIV) begin
                    multi_o = 1'b1;
                    case (funct3_i)
                        3'b000: op_o = OP_MUL;
                        3'b011: op_o = OP_MULHU;
                        3'b101: op_o = OP_DIVU;
                        3'b111: op_o = OP_REMU;
                        default: begin
                            multi_o   = 1'b0;
                            illegal_o = 1'b1;
                        end
                    endcase
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: begin
                // I-type: funct7 is immediate bits except for the shift encodings
                op_o = base_op(funct3_i);
                if (funct3_i == 3'b001 && funct7_i != F7_BASE)
                    illegal_o = 1'b1;
                if (funct3_i == 3'b101) begin
                    if (funct7_i == F7_ALT)
                        op_o = OP_SRA;
                    else if (funct7_i != F7_BASE)
                        illegal_o = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute stage with optional iterative MUL/MULHU/DIVU/REMU; 1-cycle or XLEN+1-cycle latency.
// Result holds while out_ready is low; in_ready drops while busy or holding an unconsumed result.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(XLEN - 1);

    logic [3:0]        dec_op;
    logic              dec_ill, dec_multi, fire;
    logic [SH_W-1:0]   sh;
    logic [XLEN-1:0]   alu_res;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              hi_q, hi_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    logic [XLEN:0]     mul_sum, div_r2, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    alu_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .alu_op_i  (alu_op),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .op_o      (dec_op),
        .illegal_o (dec_ill),
        .multi_o   (dec_multi)
    );

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;
    assign sh       = op_b[SH_W-1:0];

    always_comb begin
        case (dec_op)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << sh;
            OP_SRL:  alu_res = op_a >> sh;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SRA:  alu_res = $signed(op_a) >>> sh;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

    // Shift-add: acc = {partial product, remaining multiplier bits}, multiplicand in opnd_q.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}, divisor in opnd_q.
    assign div_r2   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_r2 - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {div_r2[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign step     = (state_q == MUL) ? mul_next : div_next;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire && dec_multi) begin
                    cnt_d = '0;
                    hi_d  = (dec_op == OP_MULHU) || (dec_op == OP_REMU);
                    if (dec_op == OP_MUL || dec_op == OP_MULHU) begin
                        state_d = MUL;
                        acc_d   = {{XLEN{1'b0}}, op_b};
                        opnd_d  = op_a;
                    end else begin
                        state_d = DIV;
                        acc_d   = {{XLEN{1'b0}}, op_a};
                        opnd_d  = op_b;
                    end
                end else if (fire) begin
                    out_valid_d = 1'b1;
                    result_d    = dec_ill ? '0 : alu_res;
                    illegal_d   = dec_ill;
                end
            end
            MUL, DIV: begin
                acc_d = step;
                cnt_d = cnt_q + SH_W'(1);
                // Last iteration publishes straight into the output register
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    illegal_d   = 1'b0;
                    result_d    = hi_q ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            hi_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit, with a second instance built without the M extension.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a, op_b;
    logic            out_ready;

    logic            in_ready, out_valid, illegal;
    logic [XLEN-1:0] result;
    logic            nm_in_ready, nm_out_valid, nm_illegal;
    logic [XLEN-1:0] nm_result;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result), .illegal(nm_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b[4:0];
        case (f3)
            3'd0: return a + b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void ref_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b, input bit en_m,
                                   output logic [31:0] r, output bit ill, output bit multi);
        logic [63:0] p;
        int unsigned s;
        s = b[4:0];
        p = 64'(a) * 64'(b);
        r = '0; ill = 1'b0; multi = 1'b0;
        case (aop)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin
                if (f7 == 7'h00)                   r = base_ref(f3, a, b);
                else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> s;
                else if (f7 == 7'h01 && en_m && f3 == 3'd0) begin multi = 1; r = p[31:0]; end
                else if (f7 == 7'h01 && en_m && f3 == 3'd3) begin multi = 1; r = p[63:32]; end
                else if (f7 == 7'h01 && en_m && f3 == 3'd5) begin multi = 1; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
                else if (f7 == 7'h01 && en_m && f3 == 3'd7) begin multi = 1; r = (b == 0) ? a : a % b; end
                else ill = 1'b1;
            end
            default: begin
                if (f3 == 3'd1 && f7 != 7'h00)      ill = 1'b1;
                else if (f3 == 3'd5 && f7 == 7'h20) r = $signed(a) >>> s;
                else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
                else                                r = base_ref(f3, a, b);
            end
        endcase
        if (ill) r = '0;
    endfunction

    // Issue one op with out_ready high; checks both instances, latency and busy behaviour.
    task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er, nr;
        bit ei, emul, ni, nmul, busy_ok;
        int lat;
        ref_op(aop, f3, f7, a, b, 1'b1, er, ei, emul);
        ref_op(aop, f3, f7, a, b, 1'b0, nr, ni, nmul);
        @(negedge clk);
        alu_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        op_a = $urandom; op_b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("nm_out_valid", nm_out_valid, 1);
                chk("nm_result", nm_result, nr);
                chk("nm_illegal", nm_illegal, ni);
            end
            if (out_valid || lat >= 100) break;
            if (in_ready) busy_ok = 1'b0;
        end
        chk("latency", lat, emul ? XLEN + 1 : 1);
        chk("result", result, er);
        chk("illegal", illegal, ei);
        if (emul) chk("busy_in_ready", busy_ok, 1);
        else      chk("b2b_in_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        logic [6:0] f7;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 1);

        run_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7);
        run_op(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd4);
        run_op(2'b11, 3'b101, 7'h00, 32'h8000_0000, 32'd4);
        run_op(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b10, 3'b101, 7'h01, 32'd100, 32'd0);
        run_op(2'b10, 3'b111, 7'h01, 32'd100, 32'd7);
        run_op(2'b10, 3'b111, 7'h01, 32'd100, 32'd0);
        run_op(2'b11, 3'b001, 7'h20, 32'd1, 32'd3);

        // Backpressure on a single-cycle ADD
        @(negedge clk);
        alu_op = 2'b00; funct3 = 3'd5; funct7 = 7'h55; op_a = 32'd3; op_b = 32'd4;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 7);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_consumed", out_valid, 0);

        // Reset during a divide
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'b101; funct7 = 7'h01; op_a = $urandom; op_b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);

        // Reset with a pending illegal result
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h7F; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pend_illegal", illegal, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("pend_rst_out_valid", out_valid, 0);
        chk("pend_rst_illegal", illegal, 0);

        // Random mix across all encodings
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            run_op(2'($urandom), 3'($urandom), f7,
                   ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
        end
        // Random M-extension operations
        for (int i = 0; i < 80; i++) begin
            run_op(2'b10, 3'($urandom), 7'h01,
                   ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom,
                   ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom >> $urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
